exe_issue_ctrl: RTL and testbench

Execute-stage issue controller in front of the ALU. It accepts one decoded-stage instruction plus register operands through a valid/ready handshake, then decodes it into the ALU's 13-bit one-hot `alu_control` and operand pair. It holds those stable until the ALU signals `alu_end`, which covers the multi-cycle multiply. It then presents the registered result to writeback through a second valid/ready handshake.

---
 rtl/exe_pkg.sv | 51 +++++
 rtl/exe_decode.sv | 78 +++++++
 rtl/exe_issue_ctrl.sv | 91 +++++++++
 tb/tb_exe_issue_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared ALU op indices, opcode/funct constants and FSM state type
package exe_pkg;

   localparam int ALU_W    = 13;
   localparam int ALU_MUL  = 12;
   localparam int ALU_ADD  = 11;
   localparam int ALU_SUB  = 10;
   localparam int ALU_SLT  = 9;
   localparam int ALU_SLTU = 8;
   localparam int ALU_AND  = 7;
   localparam int ALU_NOR  = 6;
   localparam int ALU_OR   = 5;
   localparam int ALU_XOR  = 4;
   localparam int ALU_SLL  = 3;
   localparam int ALU_SRL  = 2;
   localparam int ALU_SRA  = 1;
   localparam int ALU_LUI  = 0;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_MUL   = 6'h1C;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_MUL  = 6'h02;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   function automatic logic [ALU_W-1:0] alu_onehot(input int idx);
      return 13'(1) << idx;
   endfunction

endpackage

// File: rtl/exe_decode.sv
// rtl/exe_decode.sv - combinational MIPS decode into one-hot ALU op, operands and destination
module exe_decode
   import exe_pkg::*;
(
   input  logic [31:0]      inst,
   input  logic [31:0]      rs_val,
   input  logic [31:0]      rt_val,
   output logic [ALU_W-1:0] ctrl,
   output logic [31:0]      src1,
   output logic [31:0]      src2,
   output logic [4:0]       dest,
   output logic             illegal
);

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [31:0] imm_sext;
   logic [31:0] imm_zext;

   assign op       = inst[31:26];
   assign rt       = inst[20:16];
   assign rd       = inst[15:11];
   assign shamt    = inst[10:6];
   assign funct    = inst[5:0];
   assign imm_sext = {{16{inst[15]}}, inst[15:0]};
   assign imm_zext = {16'h0000, inst[15:0]};

   always_comb begin
      ctrl    = '0;
      src1    = rs_val;
      src2    = rt_val;
      dest    = rd;
      illegal = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: ctrl = alu_onehot(ALU_ADD);
               FN_SUBU: ctrl = alu_onehot(ALU_SUB);
               FN_SLT:  ctrl = alu_onehot(ALU_SLT);
               FN_SLTU: ctrl = alu_onehot(ALU_SLTU);
               FN_AND:  ctrl = alu_onehot(ALU_AND);
               FN_OR:   ctrl = alu_onehot(ALU_OR);
               FN_XOR:  ctrl = alu_onehot(ALU_XOR);
               FN_NOR:  ctrl = alu_onehot(ALU_NOR);
               // immediate shifts carry the amount in shamt, not in rs
               FN_SLL:  begin ctrl = alu_onehot(ALU_SLL); src1 = {27'b0, shamt}; end
               FN_SRL:  begin ctrl = alu_onehot(ALU_SRL); src1 = {27'b0, shamt}; end
               FN_SRA:  begin ctrl = alu_onehot(ALU_SRA); src1 = {27'b0, shamt}; end
               FN_SLLV: ctrl = alu_onehot(ALU_SLL);
               FN_SRLV: ctrl = alu_onehot(ALU_SRL);
               FN_SRAV: ctrl = alu_onehot(ALU_SRA);
               default: illegal = 1'b1;
            endcase
         end
         OP_MUL: begin
            if (funct == FN_MUL) ctrl = alu_onehot(ALU_MUL);
            else                 illegal = 1'b1;
         end
         OP_ADDIU: begin ctrl = alu_onehot(ALU_ADD);  src2 = imm_sext; dest = rt; end
         OP_SLTI:  begin ctrl = alu_onehot(ALU_SLT);  src2 = imm_sext; dest = rt; end
         OP_SLTIU: begin ctrl = alu_onehot(ALU_SLTU); src2 = imm_sext; dest = rt; end
         OP_ANDI:  begin ctrl = alu_onehot(ALU_AND);  src2 = imm_zext; dest = rt; end
         OP_ORI:   begin ctrl = alu_onehot(ALU_OR);   src2 = imm_zext; dest = rt; end
         OP_XORI:  begin ctrl = alu_onehot(ALU_XOR);  src2 = imm_zext; dest = rt; end
         OP_LUI:   begin ctrl = alu_onehot(ALU_LUI);  src2 = imm_zext; dest = rt; end
         default:  illegal = 1'b1;
      endcase
      if (illegal) begin
         ctrl = '0;
         src1 = '0;
         src2 = '0;
      end
   end

endmodule

// File: rtl/exe_issue_ctrl.sv
// rtl/exe_issue_ctrl.sv - issue FSM holding ALU controls until alu_end, then handing result to writeback
module exe_issue_ctrl
   import exe_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [31:0]      id_inst,
   input  logic [31:0]      id_rs_val,
   input  logic [31:0]      id_rt_val,
   output logic [ALU_W-1:0] alu_control,
   output logic [31:0]      alu_src1,
   output logic [31:0]      alu_src2,
   input  logic [31:0]      alu_result,
   input  logic             alu_end,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [31:0]      wb_result,
   output logic [4:0]       wb_dest,
   output logic             wb_we,
   output logic             wb_illegal
);

   state_t            state;
   logic [ALU_W-1:0]  dec_ctrl;
   logic [31:0]       dec_src1;
   logic [31:0]       dec_src2;
   logic [4:0]        dec_dest;
   logic              dec_illegal;

   exe_decode u_decode (
      .inst    (id_inst),
      .rs_val  (id_rs_val),
      .rt_val  (id_rt_val),
      .ctrl    (dec_ctrl),
      .src1    (dec_src1),
      .src2    (dec_src2),
      .dest    (dec_dest),
      .illegal (dec_illegal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         alu_control <= '0;
         alu_src1    <= '0;
         alu_src2    <= '0;
         wb_result   <= '0;
         wb_dest     <= '0;
         wb_illegal  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (id_valid) begin
                  wb_dest    <= dec_dest;
                  wb_illegal <= dec_illegal;
                  // an undecodable op never reaches the ALU, which would never end it
                  if (dec_illegal) begin
                     wb_result <= '0;
                     state     <= DONE;
                  end else begin
                     alu_control <= dec_ctrl;
                     alu_src1    <= dec_src1;
                     alu_src2    <= dec_src2;
                     state       <= EXEC;
                  end
               end
            end
            EXEC: begin
               if (alu_end) begin
                  wb_result   <= alu_result;
                  alu_control <= '0;
                  alu_src1    <= '0;
                  alu_src2    <= '0;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (wb_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign id_ready = (state == IDLE);
   assign wb_valid = (state == DONE);
   assign wb_we    = wb_valid && (wb_dest != 5'd0) && !wb_illegal;

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// tb/tb_exe_issue_ctrl.sv - self-checking bench with ALU model and result-level reference model
module tb_exe_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic        id_ready;
   logic [31:0] id_inst = '0;
   logic [31:0] id_rs_val = '0;
   logic [31:0] id_rt_val = '0;
   logic [12:0] alu_control;
   logic [31:0] alu_src1;
   logic [31:0] alu_src2;
   logic [31:0] alu_result;
   logic        alu_end;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [31:0] wb_result;
   logic [4:0]  wb_dest;
   logic        wb_we;
   logic        wb_illegal;

   logic        force_end = 1'b0;
   int          mul_cnt;
   int          checks = 0;
   int          failures = 0;

   exe_issue_ctrl dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
      .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .alu_control(alu_control),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result), .alu_end(alu_end),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result), .wb_dest(wb_dest),
      .wb_we(wb_we), .wb_illegal(wb_illegal)
   );

   always #5 clk = ~clk;

   // ALU environment: single-cycle ops end at once, mul takes 5 cycles
   always_comb begin
      alu_result = '0;
      if      (alu_control[12]) alu_result = alu_src1 * alu_src2;
      else if (alu_control[11]) alu_result = alu_src1 + alu_src2;
      else if (alu_control[10]) alu_result = alu_src1 - alu_src2;
      else if (alu_control[9])  alu_result = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
      else if (alu_control[8])  alu_result = {31'b0, alu_src1 < alu_src2};
      else if (alu_control[7])  alu_result = alu_src1 & alu_src2;
      else if (alu_control[6])  alu_result = ~(alu_src1 | alu_src2);
      else if (alu_control[5])  alu_result = alu_src1 | alu_src2;
      else if (alu_control[4])  alu_result = alu_src1 ^ alu_src2;
      else if (alu_control[3])  alu_result = alu_src2 << alu_src1[4:0];
      else if (alu_control[2])  alu_result = alu_src2 >> alu_src1[4:0];
      else if (alu_control[1])  alu_result = $signed(alu_src2) >>> alu_src1[4:0];
      else if (alu_control[0])  alu_result = alu_src2 << 16;
   end

   assign alu_end = force_end || (|alu_control[11:0]) || (alu_control[12] && mul_cnt == 4);

   always @(posedge clk) begin
      if (rst || !alu_control[12]) mul_cnt <= 0;
      else                         mul_cnt <= mul_cnt + 1;
   end

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  dest;
      logic        ill;
      logic        mul;
      logic [12:0] ctrl;
   } exp_t;

   function automatic exp_t model(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt);
      exp_t e;
      logic [5:0] op, fn;
      logic [4:0] sa;
      logic [31:0] se, ze;
      op = inst[31:26]; fn = inst[5:0]; sa = inst[10:6];
      se = {{16{inst[15]}}, inst[15:0]}; ze = {16'h0, inst[15:0]};
      e = '0;
      e.dest = inst[15:11];
      if (op == 6'h00) begin
         case (fn)
            6'h21: begin e.res = rs + rt; e.ctrl = 13'h0800; end
            6'h23: begin e.res = rs - rt; e.ctrl = 13'h0400; end
            6'h2A: begin e.res = {31'b0, $signed(rs) < $signed(rt)}; e.ctrl = 13'h0200; end
            6'h2B: begin e.res = {31'b0, rs < rt}; e.ctrl = 13'h0100; end
            6'h24: begin e.res = rs & rt; e.ctrl = 13'h0080; end
            6'h25: begin e.res = rs | rt; e.ctrl = 13'h0020; end
            6'h26: begin e.res = rs ^ rt; e.ctrl = 13'h0010; end
            6'h27: begin e.res = ~(rs | rt); e.ctrl = 13'h0040; end
            6'h00: begin e.res = rt << sa; e.ctrl = 13'h0008; end
            6'h02: begin e.res = rt >> sa; e.ctrl = 13'h0004; end
            6'h03: begin e.res = $signed(rt) >>> sa; e.ctrl = 13'h0002; end
            6'h04: begin e.res = rt << rs[4:0]; e.ctrl = 13'h0008; end
            6'h06: begin e.res = rt >> rs[4:0]; e.ctrl = 13'h0004; end
            6'h07: begin e.res = $signed(rt) >>> rs[4:0]; e.ctrl = 13'h0002; end
            default: e.ill = 1'b1;
         endcase
      end else if (op == 6'h1C && fn == 6'h02) begin
         e.res = rs * rt; e.ctrl = 13'h1000; e.mul = 1'b1;
      end else begin
         e.dest = inst[20:16];
         case (op)
            6'h09: begin e.res = rs + se; e.ctrl = 13'h0800; end
            6'h0A: begin e.res = {31'b0, $signed(rs) < $signed(se)}; e.ctrl = 13'h0200; end
            6'h0B: begin e.res = {31'b0, rs < se}; e.ctrl = 13'h0100; end
            6'h0C: begin e.res = rs & ze; e.ctrl = 13'h0080; end
            6'h0D: begin e.res = rs | ze; e.ctrl = 13'h0020; end
            6'h0E: begin e.res = rs ^ ze; e.ctrl = 13'h0010; end
            6'h0F: begin e.res = {inst[15:0], 16'h0}; e.ctrl = 13'h0001; end
            default: e.ill = 1'b1;
         endcase
      end
      if (e.ill) begin e.res = '0; e.ctrl = '0; end
      return e;
   endfunction

   logic [12:0] obs_ctrl, obs_ctrl_or;
   logic [31:0] obs_src1, obs_res;
   logic [4:0]  obs_dest;
   logic        obs_we, obs_ill, obs_accept_ok, obs_ctrl_stable, obs_busy_ready;
   logic        obs_bp_stable, obs_idle_after, obs_timeout;
   int          obs_lat, obs_exec;

   task automatic issue(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt, input int bp);
      int n;
      obs_ctrl = '0; obs_ctrl_or = '0; obs_src1 = '0; obs_exec = 0;
      obs_ctrl_stable = 1'b1; obs_busy_ready = 1'b0; obs_bp_stable = 1'b1;
      @(negedge clk);
      obs_accept_ok = id_ready;
      id_valid = 1'b1; id_inst = inst; id_rs_val = rs; id_rt_val = rt;
      @(negedge clk);
      id_valid = 1'b0; id_inst = $urandom; id_rs_val = $urandom; id_rt_val = $urandom;
      n = 1;
      while (!wb_valid && n < 60) begin
         if (alu_control != '0) begin
            if (obs_exec == 0) begin obs_ctrl = alu_control; obs_src1 = alu_src1; end
            else if (alu_control !== obs_ctrl || alu_src1 !== obs_src1) obs_ctrl_stable = 1'b0;
            obs_exec++;
         end
         obs_ctrl_or |= alu_control;
         if (id_ready) obs_busy_ready = 1'b1;
         @(negedge clk);
         n++;
      end
      obs_timeout = !wb_valid;
      obs_lat = n;
      obs_res = wb_result; obs_dest = wb_dest; obs_we = wb_we; obs_ill = wb_illegal;
      obs_ctrl_or |= alu_control;
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         if (!wb_valid || wb_result !== obs_res || wb_dest !== obs_dest || id_ready || alu_control != '0)
            obs_bp_stable = 1'b0;
      end
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      obs_idle_after = id_ready && !wb_valid;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (id_ready !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL reset_handshake got id_ready=%b wb_valid=%b exp 1 0", id_ready, wb_valid); end
      checks++; if (alu_control !== '0 || alu_src1 !== '0 || alu_src2 !== '0) begin failures++; $display("FAIL reset_alu got ctrl=%h s1=%h s2=%h exp 0", alu_control, alu_src1, alu_src2); end
      checks++; if (wb_result !== '0 || wb_dest !== '0 || wb_illegal !== 1'b0 || wb_we !== 1'b0) begin failures++; $display("FAIL reset_wb got res=%h dest=%0d ill=%b we=%b exp 0", wb_result, wb_dest, wb_illegal, wb_we); end
   endtask

   task automatic test_addiu();
      issue({6'h09, 5'd1, 5'd3, 16'hFFFF}, 32'd5, $urandom, 0);
      checks++; if (obs_ctrl !== 13'h0800) begin failures++; $display("FAIL addiu_ctrl got=%h exp=0800", obs_ctrl); end
      checks++; if (obs_res !== 32'd4 || obs_dest !== 5'd3 || obs_we !== 1'b1) begin failures++; $display("FAIL addiu_wb got res=%h dest=%0d we=%b exp 4 3 1", obs_res, obs_dest, obs_we); end
      checks++; if (obs_lat !== 2 || obs_accept_ok !== 1'b1) begin failures++; $display("FAIL addiu_latency got=%0d exp=2", obs_lat); end
   endtask

   task automatic test_shifts();
      issue({6'h00, 5'd0, 5'd2, 5'd8, 5'd4, 6'h00}, $urandom, 32'h1, 0);
      checks++; if (obs_src1 !== 32'd4 || obs_res !== 32'h10 || obs_dest !== 5'd8) begin failures++; $display("FAIL sll got src1=%h res=%h dest=%0d exp 4 10 8", obs_src1, obs_res, obs_dest); end
      issue({6'h00, 5'd1, 5'd2, 5'd9, 5'd0, 6'h07}, 32'h24, 32'h80000000, 0);
      checks++; if (obs_src1[4:0] !== 5'd4 || obs_res !== 32'hF8000000) begin failures++; $display("FAIL srav got src1=%h res=%h exp src1[4:0]=4 res=f8000000", obs_src1, obs_res); end
   endtask

   task automatic test_mul();
      issue({6'h1C, 5'd1, 5'd2, 5'd10, 5'd0, 6'h02}, 32'd7, 32'hFFFFFFFD, 0);
      checks++; if (obs_ctrl !== 13'h1000 || obs_ctrl_stable !== 1'b1 || obs_exec !== 5) begin failures++; $display("FAIL mul_ctrl got ctrl=%h stable=%b exec=%0d exp 1000 1 5", obs_ctrl, obs_ctrl_stable, obs_exec); end
      checks++; if (obs_res !== 32'hFFFFFFEB || obs_timeout) begin failures++; $display("FAIL mul_result got=%h exp=ffffffeb", obs_res); end
      checks++; if (obs_busy_ready !== 1'b0) begin failures++; $display("FAIL mul_id_ready got busy_ready=%b exp 0", obs_busy_ready); end
   endtask

   task automatic test_backpressure();
      issue({6'h0D, 5'd4, 5'd6, 16'h1234}, 32'h00F0_0000, $urandom, 3);
      checks++; if (obs_bp_stable !== 1'b1 || obs_res !== 32'h00F0_1234) begin failures++; $display("FAIL backpressure_hold got stable=%b res=%h exp 1 00f01234", obs_bp_stable, obs_res); end
      checks++; if (obs_idle_after !== 1'b1) begin failures++; $display("FAIL backpressure_release got idle=%b exp 1", obs_idle_after); end
   endtask

   task automatic test_illegal();
      issue({6'h3F, 26'h2AB_CDEF}, $urandom, $urandom, 1);
      checks++; if (obs_ill !== 1'b1 || obs_res !== '0 || obs_we !== 1'b0) begin failures++; $display("FAIL illegal_wb got ill=%b res=%h we=%b exp 1 0 0", obs_ill, obs_res, obs_we); end
      checks++; if (obs_ctrl_or !== '0 || obs_lat !== 1) begin failures++; $display("FAIL illegal_alu got ctrl_or=%h lat=%0d exp 0 1", obs_ctrl_or, obs_lat); end
      issue({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h21}, $urandom, $urandom, 0);
      checks++; if (obs_timeout || obs_we !== 1'b0 || obs_ill !== 1'b0) begin failures++; $display("FAIL rd0_we got timeout=%b we=%b ill=%b exp 0 0 0", obs_timeout, obs_we, obs_ill); end
   endtask

   task automatic test_reset_mul();
      logic seen_wb;
      @(negedge clk);
      id_valid = 1'b1; id_inst = {6'h1C, 5'd1, 5'd2, 5'd7, 5'd0, 6'h02}; id_rs_val = 32'd9; id_rt_val = 32'd9;
      @(negedge clk);
      id_valid = 1'b0;
      checks++; if (alu_control !== 13'h1000) begin failures++; $display("FAIL rstmul_exec got=%h exp=1000", alu_control); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (alu_control !== '0 || wb_valid !== 1'b0 || id_ready !== 1'b1) begin failures++; $display("FAIL rstmul_abort got ctrl=%h wb_valid=%b id_ready=%b exp 0 0 1", alu_control, wb_valid, id_ready); end
      force_end = 1'b1;
      @(negedge clk);
      force_end = 1'b0;
      seen_wb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (wb_valid || !id_ready || alu_control != '0) seen_wb = 1'b1;
         @(negedge clk);
      end
      checks++; if (seen_wb !== 1'b0) begin failures++; $display("FAIL rstmul_stray_end got disturbed=%b exp 0", seen_wb); end
      issue({6'h0D, 5'd1, 5'd5, 16'h000F}, 32'hF0, $urandom, 0);
      checks++; if (obs_res !== 32'hFF || obs_dest !== 5'd5) begin failures++; $display("FAIL rstmul_ori got res=%h dest=%0d exp ff 5", obs_res, obs_dest); end
   endtask

   task automatic test_back_to_back();
      int acc = 0, wbs = 0, bad = 0;
      @(negedge clk);
      id_inst = {6'h00, 5'd1, 5'd2, 5'd5, 5'd0, 6'h21}; id_rs_val = 32'd100; id_rt_val = 32'd23;
      id_valid = 1'b1; wb_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (id_ready) acc++;
         if (wb_valid) begin wbs++; if (wb_result !== 32'd123) bad++; end
         @(negedge clk);
      end
      id_valid = 1'b0; wb_ready = 1'b0;
      checks++; if (acc !== 10 || wbs !== 10 || bad !== 0) begin failures++; $display("FAIL back_to_back got acc=%0d wb=%0d bad=%0d exp 10 10 0", acc, wbs, bad); end
   endtask

   logic [5:0] fn_tab [14] = '{6'h21, 6'h23, 6'h2A, 6'h2B, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

   task automatic test_random();
      logic [31:0] inst, rs, rt;
      exp_t e;
      int k, exp_lat;
      for (int it = 0; it < 40; it++) begin
         k = $urandom_range(0, 23);
         inst = $urandom;
         if (k < 14)       begin inst[31:26] = 6'h00; inst[5:0] = fn_tab[k]; end
         else if (k == 14) begin inst[31:26] = 6'h1C; inst[5:0] = 6'h02; end
         else if (k < 22)  inst[31:26] = 6'(k - 15 + 9);
         else if (k == 22) inst[31:26] = 6'($urandom_range(16, 27));
         else              begin inst[31:26] = 6'h00; inst[5:0] = 6'h3F; end
         rs = $urandom; rt = $urandom;
         if (inst[0]) rs = rs & 32'h1F;
         e = model(inst, rs, rt);
         exp_lat = e.ill ? 1 : (e.mul ? 6 : 2);
         issue(inst, rs, rt, int'($urandom_range(0, 2)));
         checks++; if (obs_res !== e.res || obs_ill !== e.ill) begin failures++; $display("FAIL rand_result inst=%h got res=%h ill=%b exp res=%h ill=%b", inst, obs_res, obs_ill, e.res, e.ill); end
         checks++; if (obs_we !== (!e.ill && e.dest != 5'd0) || (!e.ill && obs_dest !== e.dest)) begin failures++; $display("FAIL rand_dest inst=%h got dest=%0d we=%b exp dest=%0d", inst, obs_dest, obs_we, e.dest); end
         checks++; if (obs_ctrl !== e.ctrl || obs_lat !== exp_lat || !obs_ctrl_stable) begin failures++; $display("FAIL rand_ctrl inst=%h got ctrl=%h lat=%0d exp ctrl=%h lat=%0d", inst, obs_ctrl, obs_lat, e.ctrl, exp_lat); end
         checks++; if (obs_bp_stable !== 1'b1 || obs_idle_after !== 1'b1 || obs_busy_ready !== 1'b0) begin failures++; $display("FAIL rand_handshake inst=%h got stable=%b idle=%b busy_ready=%b", inst, obs_bp_stable, obs_idle_after, obs_busy_ready); end
      end
   endtask

   initial begin
      test_reset();
      test_addiu();
      test_shifts();
      test_mul();
      test_backpressure();
      test_illegal();
      test_reset_mul();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
